data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 32-bit words; it SHALL be a power of 2 and at least 4.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width; it SHALL be at least log2(DEPTH)+2.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 is the clock and all logic is rising-edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 req_valid  input  1  SHALL mean a request is present.
REQ-006 req_ready  output  1  SHALL mean the block can accept a request this cycle.
REQ-007 req_we  input  1  SHALL select store (1) or load (0).
REQ-008 req_funct3  input  3  SHALL carry the RISC-V size/sign code.
REQ-009 req_addr  input  ADDR_W  SHALL carry the byte address, little-endian.
REQ-010 req_wdata  input  32  SHALL carry store data, with the data right-aligned.
REQ-011 resp_valid  output  1  SHALL mean a response is pending.
REQ-012 resp_ready  input  1  SHALL mean the consumer accepts the response.
REQ-013 resp_rdata  output  32  SHALL carry extended load data, and SHALL be 0 for stores and errors.
REQ-014 resp_err  output  1  SHALL flag a misaligned, out-of-range or illegal-funct3 request.
REQ-015 err_cnt  output  8  SHALL be a saturating count of error responses.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 req_ready SHALL equal (!resp_valid || resp_ready), giving a one-entry response register with full throughput.
REQ-018 The response SHALL appear one cycle after acceptance, with resp_valid=1, and SHALL hold stable until resp_ready=1.
REQ-019 resp_valid SHALL clear on a consumed edge unless a new request is accepted on the same edge; in that case it stays 1 with the new data.
REQ-020 Legal load funct3 values SHALL be: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-021 Legal store funct3 values SHALL be: 000 SB, 001 SH, 010 SW.
REQ-022 Every other funct3 value for the given req_we SHALL be an error.
REQ-023 Alignment SHALL be as follows: a halfword needs addr[0]=0; a word needs addr[1:0]=00; otherwise the request is an error.
REQ-024 Range: addr >= DEPTH*4 SHALL be an error; the word index SHALL be addr[log2(DEPTH)+1:2].
REQ-025 An error store SHALL NOT modify memory; an error response SHALL have resp_err=1 and resp_rdata=0.
REQ-026 A store SHALL write only the addressed byte lanes.
- SB writes lane addr[1:0] with wdata[7:0].
- SH writes lanes addr[1]*2 and +1 with wdata[15:0].
- SW writes all four lanes.
REQ-027 Store writes SHALL take effect on the accept edge.
REQ-028 A load SHALL select the byte or halfword by addr[1:0]; LB/LH SHALL sign-extend, and LBU/LHU/LW SHALL zero-extend or pass through.
REQ-029 Read-after-write: a load accepted on the cycle after a store to the same word SHALL return the stored data; no stale read is allowed.
REQ-030 Store responses SHALL return resp_err and resp_rdata=0.
REQ-031 err_cnt SHALL increment by 1 when each error response is first issued, and SHALL saturate at 255 without wrapping.
REQ-032 The FSM SHALL have states EMPTY (resp_valid=0) and FULL (resp_valid=1) with these transitions:
- EMPTY->FULL on accept.
- FULL->EMPTY on resp_ready without accept.
- FULL->FULL on accept or on stall.

Reset
REQ-033 While rst_n=0 the block SHALL force resp_valid=0, resp_rdata=0, resp_err=0 and err_cnt=0, so that req_ready=1.
REQ-034 Reset SHALL apply asynchronously on the fall of rst_n; any pending response SHALL be discarded.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 No request SHALL be accepted on the first edge at which rst_n=1 is sampled after deassertion, nor on any edge before it.

Verification
REQ-037 Scenario 1: SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> resp_rdata 0xDEADBEEF, resp_err 0, one cycle after each accept.
REQ-038 Scenario 2: SB addr 0x9 data 0x80 over word 0x11223344, then LB 0x9 -> 0xFFFFFF80; LBU 0x9 -> 0x00000080; LW 0x8 -> 0x11228044.
REQ-039 Scenario 3: LH addr 0x3; SW addr 0x6; LW addr 0x40 (DEPTH=16); load funct3 011 -> each gives resp_err 1 and rdata 0, memory is unchanged, and err_cnt=4.
REQ-040 Scenario 4: back-to-back requests with resp_ready held 0 for 3 cycles -> req_ready=0 and the response stays stable; on release, one response per cycle follows with no loss or duplication.
REQ-041 Scenario 5: 260 error requests -> err_cnt stops at 255.
REQ-042 Scenario 6: assert rst_n=0 while resp_valid=1 -> resp_valid drops immediately; the following LW returns the pre-reset stored data.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Word-organised data memory with RISC-V style byte/halfword/word loads and
// stores. Requests are accepted through a valid/ready handshake. Each accepted
// request produces one response, held in a single-entry response register that
// supports one request per cycle when the consumer keeps up.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (memory contents are kept)
//   req_valid   request present
//   req_ready   request can be accepted this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V size/sign code
//   req_addr    byte address, little-endian
//   req_wdata   store data, right-aligned
//   resp_valid  response pending
//   resp_ready  consumer accepts the response
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    misaligned, out-of-range or illegal-funct3 request
//   err_cnt     saturating count of error responses
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [7:0]        err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    if ((DEPTH < 4) || ((1 << IDX_W) != DEPTH)) begin : g_bad_depth
        $error("data_mem_ctrl: DEPTH must be a power of 2 and at least 4");
    end
    if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
        $error("data_mem_ctrl: ADDR_W too small for DEPTH");
    end

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Blocks acceptance until the first clock edge after reset release.
    logic        r_active;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic             w_accept;
    logic             w_oor;
    logic             w_misalign;
    logic             w_illegal;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_off;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_resp_data;
    logic [31:0]      w_wdata_rep;
    logic [3:0]       w_be;

    assign w_idx  = req_addr[IDX_W+1:2];
    assign w_off  = req_addr[1:0];
    assign w_word = r_mem[w_idx];

    // Any address bit above the memory span means out of range.
    if (ADDR_W > IDX_W + 2) begin : g_hi_bits
        assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_hi_bits
        assign w_oor = 1'b0;
    end

    // Request legality and alignment
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  w_misalign = 1'b0;
                3'b001:  w_misalign = w_off[0];
                3'b010:  w_misalign = |w_off;
                default: w_illegal  = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: w_misalign = 1'b0;
                3'b001, 3'b101: w_misalign = w_off[0];
                3'b010:         w_misalign = |w_off;
                default:        w_illegal  = 1'b1;
            endcase
        end
    end

    assign w_err = w_illegal | w_misalign | w_oor;

    // Load lane selection and extension
    always_comb begin
        case (w_off)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
        case (req_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = '0;
        endcase
        w_resp_data = (req_we || w_err) ? '0 : w_load;
    end

    // Store lane enables; data is replicated so every lane sees its bytes.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                w_wdata_rep = {4{req_wdata[7:0]}};
                w_be        = 4'b0001 << w_off;
            end
            2'b01: begin
                w_wdata_rep = {2{req_wdata[15:0]}};
                w_be        = w_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata_rep = req_wdata;
                w_be        = 4'b1111;
            end
        endcase
    end

    // Response FSM: next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        resp_valid  = (r_state == S_FULL);
        req_ready   = (r_state == S_EMPTY) || resp_ready;
        w_accept    = req_valid && req_ready && r_active;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (!w_accept && resp_ready) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_active  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= 1'b1;
            if (w_accept) begin
                r_rdata <= w_resp_data;
                r_err   <= w_err;
                if (w_err && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    // Memory array: not reset, written on the accept edge.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Scoreboard bench: the driver pushes the expected response when a request is
// accepted; a negedge monitor pops and compares each presented response and
// checks that stalled responses stay stable. Expected values come from a
// byte-array model of the memory.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int NBYTES = DEPTH * 4;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [7:0]        err_cnt;

    data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mdl_mem [NBYTES];
    int         mdl_errs = 0;
    int         rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, size/sign taken from funct3.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          size = 1;
        bit          sgn  = 0;
        bit          legal;
        bit          err;
        logic [31:0] v = '0;
        if (we) begin
            legal = (f3 <= 3'd2);
            if (legal) size = 1 << f3;
        end else begin
            legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            if (legal) size = 1 << f3[1:0];
            sgn = (f3 == 3'd0) || (f3 == 3'd1);
        end
        err = !legal || ((addr % size) != 0) || (addr >= NBYTES);
        if (!err) begin
            for (int k = 0; k < size; k++) begin
                if (we) mdl_mem[int'(addr) + k] = 8'(wd >> (8 * k));
                else    v = v | (32'(mdl_mem[int'(addr) + k]) << (8 * k));
            end
            if (!we && sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        end else if (mdl_errs < 255) begin
            mdl_errs++;
        end
        e.rdata = (err || we) ? 32'd0 : v;
        e.err   = err;
        e.cnt   = 8'(mdl_errs);
        return e;
    endfunction

    // Drives a request starting 2 time units after a posedge; returns on the
    // accept edge. Acceptance is judged from req_ready sampled at the negedge.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        bit done = 0;
        int c = 0;
        #2;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!done && c < 1000) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            if (ok) begin
                sb_q.push_back(model(we, f3, a, wd));
                done = 1;
            end
            c++;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        #2;
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Asserts reset asynchronously, checks reset outputs, then releases it with
    // a request already present to confirm the first edge accepts nothing.
    task automatic do_reset();
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_resp_rdata", resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        chk("rst_err_cnt",    32'(err_cnt),    32'd0);
        sb_q.delete();
        mdl_errs = 0;
        repeat (3) @(posedge clk);
        #2;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = '0;
        rst_n      = 1'b1;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        @(negedge clk);
        chk("first_edge_no_accept", 32'(resp_valid), 32'd0);
        @(posedge clk);
    endtask

    // Response consumer
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 9) < 7);
            default: resp_ready = 1'b0;
        endcase
    end

    // Monitor
    logic        held = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    logic [7:0]  held_cnt;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (resp_valid) begin
            if (held) begin
                chk("stall_rdata", resp_rdata,    held_rdata);
                chk("stall_err",   32'(resp_err), 32'(held_err));
            end else if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata,    mon_e.rdata);
                chk("resp_err",   32'(resp_err), 32'(mon_e.err));
                chk("err_cnt",    32'(err_cnt),  32'(mon_e.cnt));
            end
            held       = !resp_ready;
            held_rdata = resp_rdata;
            held_err   = resp_err;
            held_cnt   = err_cnt;
        end else begin
            if (held) chk("resp_dropped", 32'(resp_valid), 32'd1);
            held = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        we;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        rst_n      = 1'b1;
        #1;
        do_reset();

        // Initialise every word so later loads compare against known data
        rdy_mode = 0;
        for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom);
        idle(2);

        // Word store then load
        issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        idle(2);

        // Byte store into a known word, then signed/unsigned/word loads
        issue(1'b1, 3'b010, 32'h8, 32'h11223344);
        issue(1'b1, 3'b000, 32'h9, 32'h00000080);
        issue(1'b0, 3'b000, 32'h9, 32'h0);
        issue(1'b0, 3'b100, 32'h9, 32'h0);
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        issue(1'b1, 3'b001, 32'h6, 32'h0000A55A);
        issue(1'b0, 3'b001, 32'h6, 32'h0);
        issue(1'b0, 3'b101, 32'h6, 32'h0);
        idle(2);

        // Four error kinds after a fresh reset, then confirm memory unchanged
        do_reset();
        issue(1'b0, 3'b001, 32'h3,  32'h0);
        issue(1'b1, 3'b010, 32'h6,  32'hFFFFFFFF);
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        issue(1'b0, 3'b011, 32'h0,  32'h0);
        idle(3);
        chk("err_cnt_four", 32'(err_cnt), 32'd4);
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        idle(2);

        // Back-to-back requests with the consumer stalled for three cycles
        rdy_mode = 2;
        fork
            begin
                issue(1'b0, 3'b010, 32'h8,  32'h0);
                issue(1'b1, 3'b010, 32'h10, 32'h01020304);
                issue(1'b0, 3'b010, 32'h10, 32'h0);
                issue(1'b0, 3'b000, 32'h13, 32'h0);
            end
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_req_ready", 32'(req_ready), 32'd0);
                end
                rdy_mode = 0;
            end
        join
        idle(3);

        // Randomised traffic with a randomly stalling consumer
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0:       f3 = 3'b000;
                        1:       f3 = 3'b001;
                        2:       f3 = 3'b010;
                        3:       f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) < 9) a = 32'($urandom_range(0, NBYTES - 1));
            else if ($urandom_range(0, 1) == 0) a = 32'(NBYTES + $urandom_range(0, 7));
            else a = $urandom;
            issue(we, f3, a, $urandom);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 0;
        idle(4);

        // Saturation of the error counter
        for (int n = 0; n < 260; n++) issue(1'b0, 3'b010, 32'h40, 32'h0);
        idle(3);
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Reset while a response is pending; memory must survive
        issue(1'b1, 3'b010, 32'h14, 32'hCAFEF00D);
        idle(2);
        rdy_mode = 2;
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        idle(1);
        @(negedge clk);
        chk("pending_before_reset", 32'(resp_valid), 32'd1);
        #2;
        do_reset();
        rdy_mode = 0;
        issue(1'b0, 3'b010, 32'h14, 32'h0);
        issue(1'b0, 3'b010, 32'h8,  32'h0);
        idle(5);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
